// File: rtl/ebus_xfer_ctl.sv
// EBUS transfer sequencer: takes one I/O function request at a time, selects
// the target device slot, runs the DEMAND/XFER handshake under a timeout and
// returns read data or a timeout flag on a single-cycle response strobe.
module ebus_xfer_ctl #(
  parameter int NDEV    = 8,
  parameter int DATA_W  = 36,
  parameter int TIMEOUT = 31,
  localparam int DW     = (NDEV > 1) ? $clog2(NDEV) : 1,
  localparam int CW     = $clog2(TIMEOUT + 1)
) (
  input  logic                     clk,
  input  logic                     CROBAR,
  input  logic                     reqValid,
  output logic                     reqReady,
  input  logic [DW-1:0]            reqDev,
  input  logic [2:0]               reqFunc,
  input  logic [DATA_W-1:0]        reqData,
  output logic                     rspValid,
  output logic [DATA_W-1:0]        rspData,
  output logic                     rspTimeout,
  output logic                     busy,
  output logic [NDEV-1:0]          ebusCS,
  output logic [2:0]               ebusF,
  output logic                     ebusDemand,
  output logic [DATA_W-1:0]        ebusDataOut,
  input  logic [NDEV-1:0]          ebusXfer,
  input  logic [NDEV*DATA_W-1:0]   ebusDataIn
);

  typedef enum logic [2:0] {IDLE, SETUP, DEMAND, RELEASE, DONE} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic [DW-1:0]       dev_r, dev_nxt;
  logic                is_read, read_nxt;
  logic [NDEV-1:0]     cs_r, cs_nxt;
  logic [2:0]          f_r, f_nxt;
  logic [DATA_W-1:0]   dout_r, dout_nxt;
  logic                demand_r, demand_nxt;
  logic [DATA_W-1:0]   rdata_r, rdata_nxt;
  logic                rto_r, rto_nxt;
  logic                sel_xfer;
  logic [DATA_W-1:0]   sel_data;
  logic                dev_invalid;

  // Slot numbers beyond the populated range are rejected without touching the bus.
  assign dev_invalid = (32'(reqDev) >= 32'(NDEV));

  assign reqReady    = (state == IDLE) & ~CROBAR;
  assign busy        = (state != IDLE);
  assign rspValid    = (state == DONE);
  assign rspData     = rdata_r;
  assign rspTimeout  = rto_r;
  assign ebusCS      = cs_r;
  assign ebusF       = f_r;
  assign ebusDemand  = demand_r;
  assign ebusDataOut = dout_r;

  // Pick out the XFER line and read data of the latched slot only; other slots are ignored.
  always_comb begin
    sel_xfer = 1'b0;
    sel_data = '0;
    for (int i = 0; i < NDEV; i++) begin
      if (dev_r == DW'(i)) begin
        sel_xfer = ebusXfer[i];
        sel_data = ebusDataIn[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state and next-register values for the handshake sequencer.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    dev_nxt    = dev_r;
    read_nxt   = is_read;
    cs_nxt     = cs_r;
    f_nxt      = f_r;
    dout_nxt   = dout_r;
    demand_nxt = demand_r;
    rdata_nxt  = rdata_r;
    rto_nxt    = rto_r;
    case (state)
      IDLE: begin
        if (reqValid && reqReady) begin
          dev_nxt   = reqDev;
          read_nxt  = reqFunc[0];
          rdata_nxt = '0;
          rto_nxt   = 1'b0;
          cnt_nxt   = '0;
          if (dev_invalid) begin
            state_nxt = DONE;
            rto_nxt   = 1'b1;
          end else begin
            state_nxt = SETUP;
            cs_nxt    = NDEV'(1) << reqDev;
            f_nxt     = reqFunc;
            dout_nxt  = reqFunc[0] ? '0 : reqData;
          end
        end
      end
      SETUP: begin
        state_nxt  = DEMAND;
        demand_nxt = 1'b1;
        cnt_nxt    = '0;
      end
      DEMAND: begin
        if (sel_xfer) begin
          if (is_read) rdata_nxt = sel_data;
          demand_nxt = 1'b0;
          state_nxt  = RELEASE;
          cnt_nxt    = '0;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          rto_nxt    = 1'b1;
          demand_nxt = 1'b0;
          state_nxt  = RELEASE;
          cnt_nxt    = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RELEASE: begin
        if (!sel_xfer) begin
          state_nxt = DONE;
          cs_nxt    = '0;
          f_nxt     = '0;
          dout_nxt  = '0;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          rto_nxt   = 1'b1;
          rdata_nxt = '0;
          state_nxt = DONE;
          cs_nxt    = '0;
          f_nxt     = '0;
          dout_nxt  = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers; CROBAR abandons any transfer immediately.
  always_ff @(posedge clk or posedge CROBAR) begin
    if (CROBAR) begin
      state    <= IDLE;
      cnt      <= '0;
      dev_r    <= '0;
      is_read  <= 1'b0;
      cs_r     <= '0;
      f_r      <= '0;
      dout_r   <= '0;
      demand_r <= 1'b0;
      rdata_r  <= '0;
      rto_r    <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      dev_r    <= dev_nxt;
      is_read  <= read_nxt;
      cs_r     <= cs_nxt;
      f_r      <= f_nxt;
      dout_r   <= dout_nxt;
      demand_r <= demand_nxt;
      rdata_r  <= rdata_nxt;
      rto_r    <= rto_nxt;
    end
  end

endmodule
